// File: rtl/bcd_clock_pkg.sv
// Shared types, limits and BCD helpers for the time-of-day counter.
package bcd_clock_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [7:0] SEC_MAX   = 8'h59;
    localparam logic [7:0] MIN_MAX   = 8'h59;
    localparam logic [7:0] HR_MAX    = 8'h23;
    localparam logic [7:0] HR12_NOON = 8'h12;

    function automatic logic bcd_valid(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic logic [6:0] bcd2bin(input logic [7:0] b);
        return 7'({3'b000, b[7:4]} * 7'd10 + {3'b000, b[3:0]});
    endfunction

endpackage

// File: rtl/bcd_mod_digit.sv
// One BCD digit counting 0..MAX; load beats clear, clear beats increment.
module bcd_mod_digit
    import bcd_clock_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    input  logic       ld,
    input  bcd_digit_t ld_val,
    output bcd_digit_t q,
    output logic       at_max
);

    bcd_digit_t q_q, q_d;

    assign at_max = (q_q == bcd_digit_t'(MAX));
    assign q      = q_q;

    always_comb begin
        q_d = q_q;
        if (ld)
            q_d = ld_val;
        else if (clr)
            q_d = '0;
        else if (inc)
            q_d = at_max ? '0 : q_q + 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q_q <= '0;
        else
            q_q <= q_d;
    end

endmodule

// File: rtl/bcd_time_of_day.sv
// HH:MM:SS BCD clock with prescaler, 12/24-hour display, validated load and
// rollover strobes. Defining ALARM_EN adds the HH:MM alarm ports and logic.
module bcd_time_of_day
    import bcd_clock_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int DIV_W    = $clog2(TICK_DIV + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mode_12h,
    input  logic        load,
    input  logic [23:0] ld_time,
    output logic        load_err,
    output logic [3:0]  ms_hr,
    output logic [3:0]  ls_hr,
    output logic [3:0]  ms_min,
    output logic [3:0]  ls_min,
    output logic [3:0]  ms_sec,
    output logic [3:0]  ls_sec,
    output logic        pm,
    output logic        sec_pulse,
    output logic        min_roll,
    output logic        hr_roll,
`ifdef ALARM_EN
    output logic        day_roll,
    input  logic [15:0] alarm_time,
    input  logic        alarm_arm,
    input  logic        alarm_clr,
    output logic        alarm
`else
    output logic        day_roll
`endif
);

    // Digit order: 0=ls_sec .. 5=ms_hr; nibble gi holds that digit's MAX
    localparam logic [23:0] DIGIT_MAX = 24'h295959;

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick, ld_ok, ld_acc, ld_rej, adv;
    logic             sec_wrap, hr_step, day_wrap;
    logic [5:0]       inc, clr, at_max;
    bcd_digit_t       dig [6];
    logic [7:0]       hr_b;
    logic [6:0]       hr_bin, hr12;
    logic             hr12_tens;
    logic             sec_pulse_q, min_roll_q, hr_roll_q, day_roll_q, load_err_q;

    assign tick   = enable && (div_q == DIV_W'(TICK_DIV - 1));
    assign ld_ok  = bcd_valid(ld_time[23:16]) && bcd_valid(ld_time[15:8]) &&
                    bcd_valid(ld_time[7:0]) && (ld_time[23:16] <= HR_MAX) &&
                    (ld_time[15:8] <= MIN_MAX) && (ld_time[7:0] <= SEC_MAX);
    assign ld_acc = load && ld_ok;
    assign ld_rej = load && !ld_ok;
    // Any load request, good or bad, swallows a coincident tick
    assign adv    = tick && !load;

    assign sec_wrap = adv && at_max[1] && at_max[0];
    assign hr_step  = sec_wrap && at_max[3] && at_max[2];
    assign day_wrap = hr_step && at_max[5] && (dig[4] == 4'd3);

    assign inc = {inc[4] && at_max[4], hr_step && !day_wrap,
                  sec_wrap && at_max[2], sec_wrap, adv && at_max[0], adv};
    assign clr = {day_wrap, day_wrap, 4'b0000};

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            bcd_mod_digit #(
                .MAX(int'(DIGIT_MAX[4*gi +: 4]))
            ) u_digit (
                .clk    (clk),
                .reset  (reset),
                .inc    (inc[gi]),
                .clr    (clr[gi]),
                .ld     (ld_acc),
                .ld_val (ld_time[4*gi +: 4]),
                .q      (dig[gi]),
                .at_max (at_max[gi])
            );
        end
    endgenerate

    always_comb begin
        div_d = div_q;
        if (ld_acc)
            div_d = '0;
        else if (enable)
            div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q       <= '0;
            sec_pulse_q <= 1'b0;
            min_roll_q  <= 1'b0;
            hr_roll_q   <= 1'b0;
            day_roll_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            div_q       <= div_d;
            sec_pulse_q <= adv;
            min_roll_q  <= sec_wrap;
            hr_roll_q   <= hr_step;
            day_roll_q  <= day_wrap;
            load_err_q  <= ld_rej;
        end
    end

    // 12-hour view is derived from the 24-hour count, never stored
    assign hr_b   = {dig[5], dig[4]};
    assign hr_bin = bcd2bin(hr_b);

    always_comb begin
        hr12 = hr_bin;
        if (hr_bin == 7'd0)
            hr12 = 7'd12;
        else if (hr_bin > 7'd12)
            hr12 = hr_bin - 7'd12;
    end

    assign hr12_tens = (hr12 >= 7'd10);

    assign ms_hr     = mode_12h ? {3'b000, hr12_tens} : dig[5];
    assign ls_hr     = mode_12h ? 4'(hr12 - (hr12_tens ? 7'd10 : 7'd0)) : dig[4];
    assign ms_min    = dig[3];
    assign ls_min    = dig[2];
    assign ms_sec    = dig[1];
    assign ls_sec    = dig[0];
    assign pm        = (hr_b >= HR12_NOON);
    assign sec_pulse = sec_pulse_q;
    assign min_roll  = min_roll_q;
    assign hr_roll   = hr_roll_q;
    assign day_roll  = day_roll_q;
    assign load_err  = load_err_q;

`ifdef ALARM_EN
    logic        alarm_q, alarm_set;
    logic [10:0] mins_now, mins_next, mins_alarm;

    // Compare in minutes-of-day so the post-increment HH:MM needs no BCD adder
    assign mins_now   = 11'(hr_bin) * 11'd60 + 11'(bcd2bin({dig[3], dig[2]}));
    assign mins_next  = (mins_now == 11'd1439) ? 11'd0 : mins_now + 11'd1;
    assign mins_alarm = 11'(bcd2bin(alarm_time[15:8])) * 11'd60 +
                        11'(bcd2bin(alarm_time[7:0]));
    assign alarm_set  = sec_wrap && alarm_arm && (mins_next == mins_alarm);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            alarm_q <= 1'b0;
        else if (alarm_clr || !alarm_arm)
            alarm_q <= 1'b0;
        else if (alarm_set)
            alarm_q <= 1'b1;
    end

    assign alarm = alarm_q;
`endif

endmodule
